// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: owns the 12-bit PC, issues fetches, selects the next PC.
// Define FETCH_SEQ_RAS_EN to compile in the return-address stack used by CALL/RET.
module fetch_sequencer #(
    parameter logic [11:0] RESET_PC  = 12'h000,
    parameter int          IW        = 16,
    parameter int          RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          imem_req,
    output logic [11:0]   imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    input  logic          ex_done,
    input  logic [2:0]    ex_op,
    input  logic [11:0]   ex_offset,
    output logic [11:0]   pc,
    output logic          busy,
    output logic          halted,
    output logic          ras_err
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [2:0] OP_JUMP = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_HALT = 3'd4;

    // Empty marker block: elaborates only for an unsupported stack depth.
    if (RAS_DEPTH < 2 || RAS_DEPTH > 16) begin : g_ras_depth_out_of_range
    end

    state_t          state;
    logic [11:0]     pc_q;
    logic [IW-1:0]   instr_q;
    logic            instr_valid_q;
    logic            ras_err_q;
    logic [11:0]     pc_inc;
    logic [11:0]     pc_rel;

    assign pc_inc = pc_q + 12'd1;
    assign pc_rel = pc_q + ex_offset;

`ifdef FETCH_SEQ_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [11:0]   ras_mem [RAS_DEPTH];
    logic [PW-1:0] ras_wp;     // next slot to write; top of stack sits just below
    logic [CW-1:0] ras_cnt;
    logic [PW-1:0] ras_top;
    logic [PW-1:0] ras_wp_nxt;

    assign ras_top    = (ras_wp == '0) ? PW'(RAS_DEPTH - 1) : ras_wp - PW'(1);
    assign ras_wp_nxt = (ras_wp == PW'(RAS_DEPTH - 1)) ? '0 : ras_wp + PW'(1);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            ras_err_q     <= 1'b0;
`ifdef FETCH_SEQ_RAS_EN
            ras_wp        <= '0;
            ras_cnt       <= '0;
`endif
        end else begin
            instr_valid_q <= 1'b0;
            case (state)
                IDLE: if (start) state <= FETCH;
                FETCH: if (imem_ack) begin
                    instr_q       <= imem_rdata;
                    instr_valid_q <= 1'b1;
                    state         <= EXEC;
                end
                EXEC: if (ex_done) begin
                    state <= FETCH;
                    case (ex_op)
                        OP_JUMP: pc_q <= pc_rel;
                        OP_CALL: begin
                            pc_q <= pc_rel;
`ifdef FETCH_SEQ_RAS_EN
                            // Full stack: overwrite the oldest entry, keep count saturated.
                            ras_mem[ras_wp] <= pc_inc;
                            ras_wp          <= ras_wp_nxt;
                            if (ras_cnt == CW'(RAS_DEPTH)) ras_err_q <= 1'b1;
                            else                           ras_cnt   <= ras_cnt + CW'(1);
`endif
                        end
                        OP_RET: begin
`ifdef FETCH_SEQ_RAS_EN
                            if (ras_cnt == '0) begin
                                pc_q      <= pc_inc;
                                ras_err_q <= 1'b1;
                            end else begin
                                pc_q    <= ras_mem[ras_top];
                                ras_wp  <= ras_top;
                                ras_cnt <= ras_cnt - CW'(1);
                            end
`else
                            pc_q      <= pc_inc;
                            ras_err_q <= 1'b1;
`endif
                        end
                        OP_HALT: state <= HALT;
                        default: pc_q  <= pc_inc;
                    endcase
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_req    = (state == FETCH);
    assign busy        = (state == FETCH) || (state == EXEC);
    assign halted      = (state == HALT);
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign ras_err     = ras_err_q;
endmodule
